mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit wrap-to-all-ones down counter.
- Counts up or down, selected at run time, over a programmable range 0..mod_max.
- Supports synchronous load, count enable, a cascadable terminal-count output and a registered wrap pulse.
- An optional one-shot mode halts the count at terminal instead of wrapping.
- Used as the general timer/divider/sequence counter in the lab designs.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- RST_VAL, {WIDTH{1'b1}}, value of q on reset. The default reproduces the legacy 4'b1111 reset.
- ONESHOT, 0: 0 = wrap continuously; 1 = halt at terminal count until the next load.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset.
- en  input  1  Count enable; one step per enabled clk edge.
- up  input  1  Direction: 1 = increment, 0 = decrement.
- load  input  1  Synchronous load strobe.
- load_val  input  WIDTH  Value loaded on load.
- mod_max  input  WIDTH  Upper bound of the count range (inclusive).
- q  output  WIDTH  Current count, registered.
- tc  output  1  Terminal count, combinational, for cascading.
- wrap  output  1  Registered one-cycle pulse following a wrap.
- done  output  1  One-shot halted flag, registered. Always 0 when ONESHOT=0.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset: q=RST_VAL, wrap=0, done=0, state=RUN. Reset takes effect immediately, including mid-count or mid-load.
- Priority on each edge: rst > load > en. With no load and en=0, q holds and wrap=0.
- Load: q<=load_val, done<=0, wrap<=0, state<=RUN. en is ignored in that cycle. load_val > mod_max is accepted as-is.
- Count up, en=1:
  - q<mod_max: q<=q+1.
  - q>=mod_max: q<=0, wrap<=1. This also recovers from out-of-range values.
- Count down, en=1:
  - q==0: q<=mod_max, wrap<=1.
  - q>mod_max: q<=mod_max, wrap<=0 (recovery, not a wrap).
  - Otherwise: q<=q-1.
- Arithmetic is modulo 2^WIDTH internally, but the range rules above take precedence. mod_max=0 holds q at 0, with wrap pulsing every enabled cycle.
- wrap is high for exactly the one cycle after a wrapping edge, otherwise 0.
- tc = en & (up ? q==mod_max : q==0). It is combinational, so cascaded stages use it as their en.
- Direction changes take effect on the next edge with no extra latency. up may toggle every cycle.
- One-shot FSM (ONESHOT=1), states RUN and HALT:
  - RUN → HALT on an enabled edge where the terminal condition holds. In that case q stays at its terminal value (no wrap), wrap<=0 and done<=1.
  - In HALT, en is ignored and q holds.
  - HALT → RUN only on load (or on rst).
- The ONESHOT=0 build has no FSM logic, and done is tied 0.

Decomposition:
- Package counter_pkg:
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - One-shot state encoding (RUN=0, HALT=1).
  - Default width constant CNT_W=4.
- Sub-module counter_step:
  - Pure combinational next-value unit with inputs q, up, mod_max and outputs q_next, is_wrap, is_term.
  - Reused by the planned prescaler/timer blocks.
  - Top level holds the registers, priority logic and the one-shot FSM.

Test Plan (WIDTH=4 unless noted):
- Reset and legacy mode: rst=1 → q=4'hF. Release with mod_max=4'hF, up=0, en=1 → 15,14,…,0,15. wrap pulses on the cycle after 0→15. tc=1 while q=0.
- Up with modulus: mod_max=9, load 0, up=1 → 0..9,0. wrap=1 one cycle after 9→0. tc=1 only at q=9 with en=1. en=0 for 3 cycles → q holds, tc=0.
- Out-of-range recovery: mod_max=5, load_val=12. Up → next q=0 with wrap=1. Reload 12, then down → next q=5 with wrap=0.
- Priority and mid-run direction: load=1, en=1, load_val=7 → q=7 with no step. Toggle up every cycle → 8,7,8,7. Assert rst asynchronously between edges → q=4'hF immediately.
- One-shot (ONESHOT=1): mod_max=3, load 0, up=1 → 0,1,2,3, then done=1 and q stays 3 for 5 cycles despite en=1, with wrap never set. load_val=1 → done=0, counting resumes 2,3.
- Cascade (two instances, WIDTH=4): low stage tc drives the high stage en, both mod_max=9 up. After 100 enabled cycles from 0 → {hi,lo}={0,0}, with hi wrap pulsing once.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and types for the counter family.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } os_state_e;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value unit for a range-limited up/down counter.
module counter_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] q_next,
    output logic             is_wrap,
    output logic             is_term
);

    always_comb begin
        q_next  = q;
        is_wrap = 1'b0;
        is_term = 1'b0;
        if (up == DIR_UP) begin
            is_term = (q == mod_max);
            // >= also pulls out-of-range values back to zero
            if (q >= mod_max) begin
                q_next  = '0;
                is_wrap = 1'b1;
            end else begin
                q_next = q + 1'b1;
            end
        end else begin
            is_term = (q == '0);
            if (q == '0) begin
                q_next  = mod_max;
                is_wrap = 1'b1;
            end else if (q > mod_max) begin
                q_next = mod_max;
            end else begin
                q_next = q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Programmable-modulus up/down counter with load, cascade tc, wrap pulse
// and optional one-shot halt.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b1}},
    parameter bit                ONESHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    logic [WIDTH-1:0] q_next;
    logic             is_wrap;
    logic             is_term;
    logic             halted;

    counter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q      (q),
        .up     (up),
        .mod_max(mod_max),
        .q_next (q_next),
        .is_wrap(is_wrap),
        .is_term(is_term)
    );

    assign tc = en & is_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            wrap <= 1'b0;
        end else if (en && !halted) begin
            // One-shot parks on the terminal value instead of wrapping
            if (ONESHOT && is_term) begin
                wrap <= 1'b0;
            end else begin
                q    <= q_next;
                wrap <= is_wrap;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    if (ONESHOT) begin : g_oneshot
        os_state_e state;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= RUN;
            end else if (load) begin
                state <= RUN;
            end else if (en && state == RUN && is_term) begin
                state <= HALT;
            end
        end

        assign halted = (state == HALT);
        assign done   = halted;
    end else begin : g_free
        assign halted = 1'b0;
        assign done   = 1'b0;
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    int         total;
    int         passed;

    // Continuous-mode DUT
    logic       a_en, a_up, a_load;
    logic [3:0] a_load_val, a_mod_max, a_q;
    logic       a_tc, a_wrap, a_done;

    // One-shot DUT
    logic       b_en, b_up, b_load;
    logic [3:0] b_load_val, b_mod_max, b_q;
    logic       b_tc, b_wrap, b_done;

    // Cascade pair
    logic       c_en, c_load;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_wrap, lo_done, hi_tc, hi_wrap, hi_done;
    int         hi_wraps;

    mod_updown_counter #(.WIDTH(4)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_load_val), .mod_max(a_mod_max),
        .q(a_q), .tc(a_tc), .wrap(a_wrap), .done(a_done)
    );

    mod_updown_counter #(.WIDTH(4), .ONESHOT(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .up(b_up), .load(b_load),
        .load_val(b_load_val), .mod_max(b_mod_max),
        .q(b_q), .tc(b_tc), .wrap(b_wrap), .done(b_done)
    );

    mod_updown_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .load(c_load),
        .load_val(4'd0), .mod_max(4'd9),
        .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .done(lo_done)
    );

    mod_updown_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .load(c_load),
        .load_val(4'd0), .mod_max(4'd9),
        .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .done(hi_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step one clock, then sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        a_en = 0; a_up = 0; a_load = 0; a_load_val = 0; a_mod_max = 4'hF;
        b_en = 0; b_up = 1; b_load = 0; b_load_val = 0; b_mod_max = 4'd3;
        c_en = 0; c_load = 0;
        #2;
        chk("reset_q", 8'(a_q), 8'hF);
        chk("reset_wrap", 8'(a_wrap), 8'h0);
        chk("reset_done", 8'(a_done), 8'h0);
        chk("reset_done_os", 8'(b_done), 8'h0);

        // Legacy mode: down from F over full range
        rst = 1'b0; a_en = 1; a_up = 0;
        for (int i = 14; i >= 0; i--) begin
            tick();
            chk("legacy_q", 8'(a_q), 8'(i));
            chk("legacy_wrap", 8'(a_wrap), 8'h0);
            chk("legacy_tc", 8'(a_tc), 8'(i == 0));
        end
        tick();
        chk("legacy_wrap_q", 8'(a_q), 8'hF);
        chk("legacy_wrap_pulse", 8'(a_wrap), 8'h1);
        tick();
        chk("legacy_after_q", 8'(a_q), 8'hE);
        chk("legacy_after_wrap", 8'(a_wrap), 8'h0);

        // Up with modulus 9; load beats en
        a_mod_max = 4'd9; a_load = 1; a_load_val = 0; a_up = 1;
        tick();
        chk("mod9_load_q", 8'(a_q), 8'h0);
        a_load = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("mod9_q", 8'(a_q), 8'(i));
            chk("mod9_tc", 8'(a_tc), 8'(i == 9));
            chk("mod9_wrap", 8'(a_wrap), 8'h0);
        end
        a_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q", 8'(a_q), 8'h9);
            chk("hold_tc", 8'(a_tc), 8'h0);
            chk("hold_wrap", 8'(a_wrap), 8'h0);
        end
        a_en = 1;
        #1;
        chk("mod9_tc_resume", 8'(a_tc), 8'h1);
        tick();
        chk("mod9_wrap_q", 8'(a_q), 8'h0);
        chk("mod9_wrap_pulse", 8'(a_wrap), 8'h1);
        tick();
        chk("mod9_after_q", 8'(a_q), 8'h1);
        chk("mod9_after_wrap", 8'(a_wrap), 8'h0);

        // Out-of-range recovery
        a_mod_max = 4'd5; a_load = 1; a_load_val = 4'd12;
        tick();
        chk("oor_load_q", 8'(a_q), 8'hC);
        a_load = 0; a_up = 1;
        #1;
        chk("oor_tc", 8'(a_tc), 8'h0);
        tick();
        chk("oor_up_q", 8'(a_q), 8'h0);
        chk("oor_up_wrap", 8'(a_wrap), 8'h1);
        a_load = 1;
        tick();
        chk("oor_reload_q", 8'(a_q), 8'hC);
        chk("oor_reload_wrap", 8'(a_wrap), 8'h0);
        a_load = 0; a_up = 0;
        tick();
        chk("oor_down_q", 8'(a_q), 8'h5);
        chk("oor_down_wrap", 8'(a_wrap), 8'h0);

        // mod_max = 0 pins q at 0 with wrap each enabled cycle
        a_mod_max = 4'd0; a_load = 1; a_load_val = 4'd0; a_up = 1;
        tick();
        a_load = 0;
        tick();
        chk("mod0_q", 8'(a_q), 8'h0);
        chk("mod0_wrap", 8'(a_wrap), 8'h1);
        a_up = 0;
        tick();
        chk("mod0_down_q", 8'(a_q), 8'h0);
        chk("mod0_down_wrap", 8'(a_wrap), 8'h1);

        // Priority and per-cycle direction toggling
        a_mod_max = 4'hF; a_load = 1; a_load_val = 4'd7; a_en = 1; a_up = 1;
        tick();
        chk("prio_q", 8'(a_q), 8'h7);
        a_load = 0;
        for (int i = 0; i < 4; i++) begin
            a_up = (i % 2 == 0);
            tick();
            chk("toggle_q", 8'(a_q), (i % 2 == 0) ? 8'h8 : 8'h7);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q", 8'(a_q), 8'hF);
        chk("async_rst_wrap", 8'(a_wrap), 8'h0);
        #1;
        rst = 1'b0;
        a_en = 0;

        // One-shot
        b_load = 1; b_load_val = 0; b_en = 1; b_up = 1;
        tick();
        chk("os_load_q", 8'(b_q), 8'h0);
        b_load = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("os_q", 8'(b_q), 8'(i));
            chk("os_done", 8'(b_done), 8'h0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("os_halt_q", 8'(b_q), 8'h3);
            chk("os_halt_done", 8'(b_done), 8'h1);
            chk("os_halt_wrap", 8'(b_wrap), 8'h0);
        end
        b_load = 1; b_load_val = 4'd1;
        tick();
        chk("os_reload_q", 8'(b_q), 8'h1);
        chk("os_reload_done", 8'(b_done), 8'h0);
        b_load = 0;
        tick();
        chk("os_resume_q", 8'(b_q), 8'h2);
        tick();
        chk("os_resume_q2", 8'(b_q), 8'h3);
        chk("os_resume_done", 8'(b_done), 8'h0);
        tick();
        chk("os_rehalt_done", 8'(b_done), 8'h1);
        chk("os_rehalt_q", 8'(b_q), 8'h3);

        // Cascade: 100 enabled cycles from 00 returns to 00
        c_load = 1;
        tick();
        c_load = 0; c_en = 1;
        hi_wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (hi_wrap) hi_wraps++;
            if (i == 57) begin
                chk("casc_mid_hi", 8'(hi_q), 8'h5);
                chk("casc_mid_lo", 8'(lo_q), 8'h7);
            end
        end
        chk("casc_hi", 8'(hi_q), 8'h0);
        chk("casc_lo", 8'(lo_q), 8'h0);
        chk("casc_hi_wrap_now", 8'(hi_wrap), 8'h1);
        chk("casc_hi_wraps", 8'(hi_wraps), 8'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
